// File: rtl/ysyx_22040125_lsu.sv
// Load/store unit between EX and WB: one outstanding req/gnt/rvalid data-memory access.
// Build option LSU_MISALIGN_TRAP_EN: trap misaligned accesses instead of forcing alignment.
module ysyx_22040125_lsu #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic              ex_we,
  input  logic [1:0]        ex_size,
  input  logic              ex_unsigned,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [63:0]       ex_wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [63:0]       mem_wdata,
  output logic [7:0]        mem_wstrb,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [63:0]       mem_rdata,
  output logic              wb_valid,
  output logic [63:0]       wb_data,
  output logic              wb_err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_R, RESP} state_t;

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  state_t            state;
  logic              we_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [2:0]        off_q;
  logic [CNT_W-1:0]  cnt;

  logic [ADDR_W-1:0] eff_addr;
  logic              trap;
  logic [63:0]       shifted;
  logic [63:0]       load_result;

  // Offset bits that must be zero for an access of the given size.
  function automatic logic [2:0] low_mask(input logic [1:0] size);
    case (size)
      2'd0:    low_mask = 3'b000;
      2'd1:    low_mask = 3'b001;
      2'd2:    low_mask = 3'b011;
      default: low_mask = 3'b111;
    endcase
  endfunction

  function automatic logic [7:0] strobe(input logic [1:0] size, input logic [2:0] off);
    case (size)
      2'd0:    strobe = 8'h01 << off;
      2'd1:    strobe = 8'h03 << off;
      2'd2:    strobe = 8'h0F << off;
      default: strobe = 8'hFF;
    endcase
  endfunction

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap     = |(ex_addr[2:0] & low_mask(ex_size));
  assign eff_addr = ex_addr;
`else
  assign trap     = 1'b0;
  assign eff_addr = {ex_addr[ADDR_W-1:3], ex_addr[2:0] & ~low_mask(ex_size)};
`endif

  // NOTE: every variable driven here gets a default first, so no latch can be inferred.
  always_comb begin
    shifted     = mem_rdata >> {off_q, 3'b000};
    load_result = mem_rdata;
    case (size_q)
      2'd0:    load_result = {{56{~uns_q & shifted[7]}},  shifted[7:0]};
      2'd1:    load_result = {{48{~uns_q & shifted[15]}}, shifted[15:0]};
      2'd2:    load_result = {{32{~uns_q & shifted[31]}}, shifted[31:0]};
      default: load_result = mem_rdata;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every branch reads pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ex_ready  <= 1'b1;
      we_q      <= 1'b0;
      size_q    <= 2'd0;
      uns_q     <= 1'b0;
      off_q     <= 3'd0;
      cnt       <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      wb_valid  <= 1'b0;
      wb_data   <= '0;
      wb_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ex_valid) begin
            we_q      <= ex_we;
            size_q    <= ex_size;
            uns_q     <= ex_unsigned;
            off_q     <= eff_addr[2:0];
            cnt       <= '0;
            mem_we    <= ex_we;
            mem_addr  <= {eff_addr[ADDR_W-1:3], 3'b000};
            mem_wdata <= ex_wdata;
            mem_wstrb <= ex_we ? strobe(ex_size, eff_addr[2:0]) : 8'h00;
            ex_ready  <= 1'b0;
            if (trap) begin
              wb_valid <= 1'b1;
              wb_err   <= 1'b1;
              wb_data  <= '0;
              state    <= RESP;
            end else begin
              mem_req <= 1'b1;
              state   <= REQ;
            end
          end
        end
        REQ: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            if (we_q) begin
              wb_valid <= 1'b1;
              wb_data  <= '0;
              state    <= RESP;
            end else if (mem_rvalid) begin
              wb_valid <= 1'b1;
              wb_data  <= load_result;
              state    <= RESP;
            end else begin
              state <= WAIT_R;
            end
          end
        end
        WAIT_R: begin
          cnt <= cnt + 1'b1;
          if (mem_rvalid) begin
            wb_valid <= 1'b1;
            wb_data  <= load_result;
            state    <= RESP;
          end else if (TIMEOUT != 0 && cnt == CNT_W'(TIMEOUT - 1)) begin
            wb_valid <= 1'b1;
            wb_err   <= 1'b1;
            wb_data  <= '0;
            state    <= RESP;
          end
        end
        default: begin
          wb_valid <= 1'b0;
          wb_data  <= '0;
          wb_err   <= 1'b0;
          ex_ready <= 1'b1;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22040125_lsu.sv
// Randomized bench for ysyx_22040125_lsu against a byte-level reference model and memory responder.
module tb_ysyx_22040125_lsu;
  localparam int TO = 4;

  logic        clk, rst_n;
  logic        ex_valid, ex_ready, ex_we, ex_unsigned;
  logic [1:0]  ex_size;
  logic [31:0] ex_addr;
  logic [63:0] ex_wdata;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr;
  logic [63:0] mem_wdata, mem_rdata;
  logic [7:0]  mem_wstrb;
  logic        wb_valid, wb_err;
  logic [63:0] wb_data;

  int n_checks = 0;
  int n_errors = 0;

  ysyx_22040125_lsu #(.ADDR_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_we(ex_we), .ex_size(ex_size),
    .ex_unsigned(ex_unsigned), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_err(wb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: strobe is the set of byte lanes [o, o+n).
  function automatic logic [7:0] m_strb(input int o, input int n);
    logic [7:0] s = '0;
    for (int b = 0; b < 8; b++) if (b >= o && b < o + n) s[b] = 1'b1;
    return s;
  endfunction

  function automatic logic [63:0] m_load(input logic [63:0] rd, input int o, input int n, input bit uns);
    logic [63:0] v, mask;
    v = rd >> (8 * o);
    if (n < 8) begin
      mask = (64'd1 << (8 * n)) - 64'd1;
      v = v & mask;
      if (!uns && v[8*n-1]) v = v | ~mask;
    end
    return v;
  endfunction

  // rv_wait: cycles after gnt until rvalid (0 = same cycle as gnt, negative = never).
  task automatic run_txn(input bit we, input logic [1:0] sz, input bit uns, input logic [31:0] addr,
                         input logic [63:0] wdata, input logic [63:0] rdata,
                         input int gnt_wait, input int rv_wait);
    int          n, exp_lat, req_cnt, post;
    bit          trap, timed_out, exp_err, gnt_done, req_checked, saw_req, done;
    logic [31:0] eff;
    logic [63:0] exp_data;
    n = 1 << sz;
`ifdef LSU_MISALIGN_TRAP_EN
    trap = (addr % n) != 0;
    eff  = addr;
`else
    trap = 1'b0;
    eff  = addr - (addr % n);
`endif
    timed_out = !we && !trap && (rv_wait < 0 || rv_wait > TO);
    exp_err   = trap || timed_out;
    exp_lat   = trap ? 1 : 2 + gnt_wait + (we ? 0 : (timed_out ? TO : rv_wait));
    exp_data  = (we || exp_err) ? 64'd0 : m_load(rdata, int'(eff % 8), n, uns);

    @(negedge clk);
    check("ready_idle", ex_ready, 1);
    ex_valid = 1; ex_we = we; ex_size = sz; ex_unsigned = uns; ex_addr = addr; ex_wdata = wdata;
    mem_gnt = 0; mem_rvalid = 0;
    @(negedge clk);
    ex_valid = 0; ex_addr = $urandom; ex_wdata = {$urandom, $urandom};
    req_cnt = 0; post = 0; gnt_done = 0; req_checked = 0; saw_req = 0; done = 0;
    for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
      if (cyc > 1) @(negedge clk);
      mem_gnt = 0; mem_rvalid = 0; mem_rdata = {$urandom, $urandom};
      if (wb_valid) begin
        done = 1;
        check("latency", cyc, exp_lat);
        check("wb_data", wb_data, exp_data);
        check("wb_err", wb_err, exp_err);
      end else begin
        if (cyc == 1) check("ready_busy", ex_ready, 0);
        if (mem_req) begin
          saw_req = 1;
          if (!req_checked) begin
            req_checked = 1;
            check("mem_addr", mem_addr, eff & ~32'd7);
            check("mem_we", mem_we, we);
            check("mem_wstrb", mem_wstrb, we ? m_strb(int'(eff % 8), n) : 8'h00);
            if (we) check("mem_wdata", mem_wdata, wdata);
          end
          if (req_cnt == gnt_wait) begin
            mem_gnt = 1; gnt_done = 1;
            if (!we && rv_wait == 0) begin mem_rvalid = 1; mem_rdata = rdata; end
          end else begin
            mem_rvalid = 1'($urandom % 2);
          end
          req_cnt++;
        end else if (gnt_done && !we) begin
          post++;
          if (post == rv_wait) begin mem_rvalid = 1; mem_rdata = rdata; end
        end
      end
    end
    if (!done) check("wb_valid_timeout", 0, 1);
    check("req_seen", saw_req, !trap);
    @(negedge clk);
    mem_gnt = 0; mem_rvalid = 0;
    check("wb_pulse", wb_valid, 0);
    check("ready_after", ex_ready, 1);
  endtask

  initial begin
    bit seen;
    rst_n = 0; ex_valid = 0; ex_we = 0; ex_size = 0; ex_unsigned = 0; ex_addr = 0; ex_wdata = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    #12;
    check("rst_ready", ex_ready, 1);
    check("rst_req", mem_req, 0);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_wb_data", wb_data, 0);
    check("rst_wstrb", mem_wstrb, 0);
    @(negedge clk); rst_n = 1;

    run_txn(1, 2'd0, 0, 32'h8000_0005, 64'hABAB_ABAB_ABAB_ABAB, 64'd0, 0, 0);
    run_txn(0, 2'd1, 0, 32'h8000_0006, 64'd0, 64'h8001_0000_0000_0000, 0, 3);
    run_txn(0, 2'd1, 1, 32'h8000_0006, 64'd0, 64'h8001_0000_0000_0000, 0, 3);
    run_txn(0, 2'd2, 0, 32'h0000_1004, 64'd0, 64'h1234_5678_9ABC_DEF0, 0, 0);
    run_txn(1, 2'd2, 0, 32'h0000_1002, 64'h5555_6666_5555_6666, 64'd0, 1, 0);
    run_txn(0, 2'd2, 0, 32'h0000_1002, 64'd0, 64'hFEDC_BA98_7654_3210, 0, 1);
    run_txn(0, 2'd3, 1, 32'h0000_2000, 64'd0, 64'h1, 0, -1);
    run_txn(0, 2'd0, 0, 32'h0000_2007, 64'd0, 64'h80FF_FFFF_FFFF_FFFF, 2, TO);

    // Reset while waiting for read data abandons the load.
    @(negedge clk);
    ex_valid = 1; ex_we = 0; ex_size = 2'd3; ex_addr = 32'h0000_0100;
    @(negedge clk); ex_valid = 0; mem_gnt = 1;
    @(negedge clk); mem_gnt = 0;
    @(negedge clk);
    rst_n = 0; #1;
    check("midrst_ready", ex_ready, 1);
    check("midrst_req", mem_req, 0);
    check("midrst_wb_valid", wb_valid, 0);
    check("midrst_addr", mem_addr, 0);
    @(negedge clk); rst_n = 1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 2) begin mem_rvalid = 1; mem_rdata = 64'hFFFF; end else mem_rvalid = 0;
      if (wb_valid) seen = 1;
    end
    mem_rvalid = 0;
    check("midrst_no_wb", seen, 0);

    for (int t = 0; t < 300; t++) begin
      int rv;
      rv = ($urandom % 8 == 0) ? -1 : int'($urandom_range(0, 6));
      run_txn(1'($urandom % 2), 2'($urandom % 4), 1'($urandom % 2), $urandom,
              {$urandom, $urandom}, {$urandom, $urandom}, int'($urandom_range(0, 3)), rv);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
